// File: rtl/pe_column_result_drain.sv
// Result drain for the sparse PE column: snapshots N packed PE words into a shadow bank on
// tile end (clearing the column in the same cycle) and streams them out one word per beat.
module pe_column_result_drain #(
  parameter int N     = 32,
  parameter int RES_W = 52,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tile_done,
  input  logic [RES_W*N-1:0] pe_result,
  output logic               tile_ack,
  output logic               col_clr,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [RES_W-1:0]   m_data,
  output logic [IDX_W-1:0]   m_index,
  output logic               m_last,
  output logic               busy,
  output logic [CNT_W-1:0]   tile_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [RES_W*N-1:0] r_shadow;
  logic [CNT_W-1:0]   r_tile_cnt;

  logic w_valid;
  logic w_at_last;
  logic w_beat;
  logic w_final_beat;
  logic w_can_cap;
  logic w_accept;

  assign w_valid      = (r_state == S_DRAIN);
  assign w_at_last    = (r_idx == IDX_W'(N - 1));
  assign w_beat       = w_valid && m_ready;
  assign w_final_beat = w_beat && w_at_last;
  // A new snapshot is taken only when the bank is free or is being vacated this very cycle.
  assign w_can_cap    = (r_state == S_IDLE) || w_final_beat;
  assign w_accept     = tile_done && w_can_cap && !rst;

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_DRAIN;
          w_idx_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if (w_final_beat) begin
          w_idx_nxt   = '0;
          w_state_nxt = w_accept ? S_DRAIN : S_IDLE;
        end else if (w_beat) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // NOTE: the shadow bank is reset because idle-state m_data must read back as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_tile_cnt <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_shadow <= pe_result;
      end
      if (w_final_beat) begin
        r_tile_cnt <= r_tile_cnt + CNT_W'(1);
      end
    end
  end

  assign tile_ack = w_accept;
  assign col_clr  = w_accept;
  assign m_valid  = w_valid;
  assign m_data   = r_shadow[RES_W*int'(r_idx) +: RES_W];
  assign m_index  = r_idx;
  assign m_last   = w_valid && w_at_last;
  assign busy     = w_valid;
  assign tile_cnt = r_tile_cnt;

endmodule

// File: tb/tb_pe_column_result_drain.sv
// Directed bench for pe_column_result_drain: a scoreboard queue holds the words each accepted
// tile must produce, and a small state model predicts valid/ack/tile count every cycle.
module tb_pe_column_result_drain;

  localparam int N     = 4;
  localparam int RES_W = 52;
  localparam int IDX_W = 2;
  localparam int CNT_W = 4;

  typedef struct {
    logic [RES_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               tile_done;
  logic [RES_W*N-1:0] pe_result;
  logic               tile_ack;
  logic               col_clr;
  logic               m_valid;
  logic               m_ready;
  logic [RES_W-1:0]   m_data;
  logic [IDX_W-1:0]   m_index;
  logic               m_last;
  logic               busy;
  logic [CNT_W-1:0]   tile_cnt;

  exp_t             sb[$];
  logic [RES_W-1:0] cur_words[N];
  logic [CNT_W-1:0] exp_cnt;
  bit               got_ack;
  int               n_assert;
  int               n_fail;

  pe_column_result_drain #(.N(N), .RES_W(RES_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .tile_done(tile_done), .pe_result(pe_result),
    .tile_ack(tile_ack), .col_clr(col_clr), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last), .busy(busy), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    int   r;
    logic exp_ack;
    exp_t e;
    @(negedge clk);
    r       = sb.size();
    exp_ack = tile_done && !rst && (r == 0 || (r == 1 && m_ready));
    check("m_valid", m_valid, r != 0);
    check("busy", busy, r != 0);
    check("tile_ack", tile_ack, exp_ack);
    check("col_clr", col_clr, exp_ack);
    if (r != 0) begin
      e = sb[0];
      check("m_data", m_data, e.data);
      check("m_index", m_index, e.idx);
      check("m_last", m_last, e.last);
      if (m_ready) begin
        void'(sb.pop_front());
        if (e.last) exp_cnt = exp_cnt + CNT_W'(1);
      end
    end else begin
      check("m_last_idle", m_last, 1'b0);
    end
    if (exp_ack) begin
      got_ack = 1'b1;
      for (int i = 0; i < N; i++) begin
        e.data = cur_words[i];
        e.idx  = IDX_W'(i);
        e.last = (i == N - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("tile_cnt", tile_cnt, exp_cnt);
  endtask

  task automatic send_tile(input logic [RES_W-1:0] base, input bit rnd, output int waited);
    for (int i = 0; i < N; i++) begin
      cur_words[i] = rnd ? RES_W'({$urandom, $urandom}) : base + RES_W'(i);
      pe_result[i*RES_W +: RES_W] = cur_words[i];
    end
    tile_done = 1'b1;
    got_ack   = 1'b0;
    waited    = 0;
    while (!got_ack && waited < 100) begin
      tick();
      waited++;
    end
    if (!got_ack) check("ack_timeout", 64'd0, 64'd1);
    tile_done = 1'b0;
    pe_result = '1;
  endtask

  task automatic drain(input bit bp);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      m_ready = bp ? (k % 3 == 0) : 1'b1;
      tick();
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    m_ready = 1'b1;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    sb.delete();
    exp_cnt = '0;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_index", m_index, 64'd0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tile_ack", tile_ack, 1'b0);
    check("rst_col_clr", col_clr, 1'b0);
    check("rst_tile_cnt", tile_cnt, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int w;
    n_assert  = 0;
    n_fail    = 0;
    exp_cnt   = '0;
    rst       = 1'b1;
    tile_done = 1'b0;
    m_ready   = 1'b1;
    pe_result = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // T1: asynchronous reset mid-cycle, then idle with no request
    tick();
    async_reset();
    repeat (3) tick();

    // T2: single tile, consumer always ready
    send_tile(52'h1, 1'b0, w);
    check("t2_ack_latency", 64'(w), 64'd1);
    drain(1'b0);
    tick();
    check("t2_idle_after", m_valid, 1'b0);
    check("t2_tile_cnt", tile_cnt, 64'd1);

    // T3: backpressure pattern 1,0,0,1,...
    send_tile(52'hF_0000_0000_0010, 1'b0, w);
    drain(1'b1);
    check("t3_tile_cnt", tile_cnt, 64'd2);

    // T4: new tile requested at drain beat 1 stalls until the last beat, then no bubble
    send_tile(52'h5, 1'b0, w);
    tick();
    send_tile(52'hA, 1'b0, w);
    check("t4_stall_cycles", 64'(w), 64'd3);
    drain(1'b0);
    check("t4_tile_cnt", tile_cnt, 64'd4);

    // T5: reset after two beats loses the tile and leaves the count at zero
    async_reset();
    send_tile(52'h20, 1'b0, w);
    tick();
    tick();
    async_reset();
    tick();
    send_tile(52'h100, 1'b0, w);
    drain(1'b0);
    check("t5_tile_cnt", tile_cnt, 64'd1);

    // T6: 2^CNT_W back-to-back random tiles wrap the counter
    async_reset();
    for (int t = 0; t < (1 << CNT_W); t++) send_tile('0, 1'b1, w);
    drain(1'b0);
    check("t6_wrap", tile_cnt, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
